// File: rtl/bezier_pkg.sv
// rtl/bezier_pkg.sv - shared constants, state enum and array types for the Bezier stepper
// Contents: AXES, S_ONE, POS_W, CP_W, S_W, DELTA_W, state_t, point_t, pos_t, endpoint()
package bezier_pkg;
   localparam int AXES    = 3;
   localparam int S_ONE   = 65536;
   localparam int POS_W   = 18;
   localparam int CP_W    = 32;
   localparam int S_W     = 17;
   localparam int DELTA_W = 19;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_EMIT,
      ST_FINAL,
      ST_DONE
   } state_t;

   typedef logic signed [CP_W-1:0]  point_t [AXES];
   typedef logic signed [POS_W-1:0] pos_t   [AXES];

   // Whole-step endpoint of a 16.16 coordinate (floor).
   function automatic logic signed [POS_W-1:0] endpoint(input logic signed [CP_W-1:0] p);
      return POS_W'(p >>> 16);
   endfunction
endpackage

// File: rtl/bezier_eval.sv
// rtl/bezier_eval.sv - combinational cubic Bezier evaluator with P0 = 0
// Ports: p1/p2/p3 control points (16.16), s curve parameter (Q0.16), steps floor(B(s)) per axis
module bezier_eval
   import bezier_pkg::*;
(
   input  logic signed [CP_W-1:0]  p1    [AXES],
   input  logic signed [CP_W-1:0]  p2    [AXES],
   input  logic signed [CP_W-1:0]  p3    [AXES],
   input  logic signed [S_W-1:0]   s,
   output logic signed [POS_W-1:0] steps [AXES]
);
   localparam int W_W   = 50;
   localparam int ACC_W = 82;

   logic [S_W-1:0] u;
   logic [W_W-1:0] u_e, s_e, w1, w2, w3;
   logic signed [ACC_W-1:0] acc [AXES];

   // Bernstein weights are Q0.48; times 16.16 points gives 64 fraction bits.
   always_comb begin
      u   = S_W'(S_ONE) - $unsigned(s);
      u_e = W_W'(u);
      s_e = W_W'($unsigned(s));
      w1  = W_W'(3) * u_e * u_e * s_e;
      w2  = W_W'(3) * u_e * s_e * s_e;
      w3  = s_e * s_e * s_e;
      for (int i = 0; i < AXES; i++) begin
         acc[i]   = $signed({32'd0, w1}) * ACC_W'(p1[i])
                  + $signed({32'd0, w2}) * ACC_W'(p2[i])
                  + $signed({32'd0, w3}) * ACC_W'(p3[i]);
         steps[i] = POS_W'(acc[i] >>> 64);
      end
   end
endmodule

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - per-axis step/direction pulse generator
// Ports: clk, reset, run (emit enabled), delta (target - pos), step, dir,
//        pos_step (+1/-1 on the falling edge of step, else 0), idle
module step_pulse_gen
   import bezier_pkg::*;
#(
   parameter int PULSE_W = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run,
   input  logic signed [DELTA_W-1:0] delta,
   output logic                      step,
   output logic                      dir,
   output logic signed [1:0]         pos_step,
   output logic                      idle
);
   localparam int CNT_W = $clog2(PULSE_W + 1);

   typedef enum logic [1:0] {PH_IDLE, PH_ARM, PH_HIGH, PH_LOW} phase_t;

   phase_t             phase, phase_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               dir_n;
   logic               last;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= PH_IDLE;
         cnt   <= '0;
         dir   <= 1'b0;
      end else begin
         phase <= phase_n;
         cnt   <= cnt_n;
         dir   <= dir_n;
      end
   end

   // PH_ARM is a low cycle after dir is updated, so dir always leads the rising edge.
   always_comb begin
      phase_n  = phase;
      cnt_n    = cnt;
      dir_n    = dir;
      last     = (cnt == CNT_W'(PULSE_W - 1));
      case (phase)
         PH_IDLE: begin
            if (run && (delta != '0)) begin
               dir_n   = ~delta[DELTA_W-1];
               phase_n = PH_ARM;
            end
         end
         PH_ARM: begin
            phase_n = PH_HIGH;
            cnt_n   = '0;
         end
         PH_HIGH: begin
            if (last) begin
               phase_n = PH_LOW;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         PH_LOW: begin
            if (last) begin
               phase_n = PH_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: phase_n = PH_IDLE;
      endcase
   end

   assign step     = (phase == PH_HIGH);
   assign idle     = (phase == PH_IDLE);
   assign pos_step = (step && last) ? (dir ? 2'sd1 : -2'sd1) : 2'sd0;
endmodule

// File: rtl/bezier_stepper.sv
// rtl/bezier_stepper.sv - sweeps s over one Bezier segment and emits step/dir pulses
// Ports: clk, reset, seg_valid/seg_ready handshake, seg_p1..p3, seg_ds, seg_period,
//        step, dir, pos, busy, done, underrun
module bezier_stepper
   import bezier_pkg::*;
#(
   parameter int PULSE_W = 4,
   parameter int PER_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    seg_valid,
   output logic                    seg_ready,
   input  logic signed [CP_W-1:0]  seg_p1 [AXES],
   input  logic signed [CP_W-1:0]  seg_p2 [AXES],
   input  logic signed [CP_W-1:0]  seg_p3 [AXES],
   input  logic signed [S_W-1:0]   seg_ds,
   input  logic [PER_W-1:0]        seg_period,
   output logic [AXES-1:0]         step,
   output logic [AXES-1:0]         dir,
   output logic signed [POS_W-1:0] pos [AXES],
   output logic                    busy,
   output logic                    done,
   output logic                    underrun
);
   state_t                    state, state_n;
   point_t                    p1_q, p2_q, p3_q;
   pos_t                      target, eval_steps;
   logic signed [S_W-1:0]     s_q, ds_q;
   logic [PER_W-1:0]          period_q, per_cnt, period_load;
   logic signed [DELTA_W-1:0] delta [AXES];
   logic signed [1:0]         pos_step [AXES];
   logic [AXES-1:0]           delta_nz, gen_idle;
   logic [S_W:0]              s_sum;
   logic                      per_expired, emit_exit, sum_last, run;

   bezier_eval u_eval (
      .p1    (p1_q),
      .p2    (p2_q),
      .p3    (p3_q),
      .s     (s_q),
      .steps (eval_steps)
   );

   for (genvar g = 0; g < AXES; g++) begin : g_axis
      step_pulse_gen #(.PULSE_W(PULSE_W)) u_gen (
         .clk      (clk),
         .reset    (reset),
         .run      (run),
         .delta    (delta[g]),
         .step     (step[g]),
         .dir      (dir[g]),
         .pos_step (pos_step[g]),
         .idle     (gen_idle[g])
      );
   end

   always_comb begin
      run         = (state == ST_EMIT);
      period_load = (period_q == '0) ? PER_W'(1) : period_q;
      s_sum       = {s_q[S_W-1], s_q} + {ds_q[S_W-1], ds_q};
      sum_last    = (s_sum >= (S_W+1)'(S_ONE));
      per_expired = (per_cnt <= PER_W'(1));
      for (int i = 0; i < AXES; i++) begin
         delta[i]    = DELTA_W'(target[i]) - DELTA_W'(pos[i]);
         delta_nz[i] = (delta[i] != '0);
      end
      emit_exit = run && per_expired && (delta_nz == '0) && (&gen_idle);
   end

   // The FINAL pass reuses ST_EMIT; p3 endpoint in target marks it via a separate flag.
   logic final_q;

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:   if (seg_valid) state_n = ST_SAMPLE;
         ST_SAMPLE: state_n = ST_EMIT;
         ST_EMIT: begin
            if (emit_exit) begin
               if (final_q)       state_n = ST_DONE;
               else if (sum_last) state_n = ST_FINAL;
               else               state_n = ST_SAMPLE;
            end
         end
         ST_FINAL:  state_n = ST_EMIT;
         ST_DONE:   state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         final_q  <= 1'b0;
         s_q      <= '0;
         ds_q     <= '0;
         period_q <= '0;
         per_cnt  <= '0;
         underrun <= 1'b0;
         for (int i = 0; i < AXES; i++) begin
            p1_q[i]   <= '0;
            p2_q[i]   <= '0;
            p3_q[i]   <= '0;
            target[i] <= '0;
            pos[i]    <= '0;
         end
      end else begin
         state <= state_n;
         for (int i = 0; i < AXES; i++)
            pos[i] <= pos[i] + POS_W'(pos_step[i]);
         case (state)
            ST_IDLE: begin
               if (seg_valid) begin
                  p1_q     <= seg_p1;
                  p2_q     <= seg_p2;
                  p3_q     <= seg_p3;
                  ds_q     <= seg_ds;
                  period_q <= seg_period;
                  s_q      <= '0;
                  final_q  <= 1'b0;
                  for (int i = 0; i < AXES; i++) begin
                     pos[i]    <= '0;
                     target[i] <= '0;
                  end
               end
            end
            ST_SAMPLE: begin
               target  <= eval_steps;
               per_cnt <= period_load;
            end
            ST_FINAL: begin
               for (int i = 0; i < AXES; i++)
                  target[i] <= endpoint(p3_q[i]);
               final_q <= 1'b1;
               per_cnt <= period_load;
            end
            ST_EMIT: begin
               if (per_cnt != '0)
                  per_cnt <= per_cnt - PER_W'(1);
               // Period overrun stretches the sample; steps are never dropped.
               if (per_expired && (delta_nz != '0))
                  underrun <= 1'b1;
               if (emit_exit && !final_q && !sum_last)
                  s_q <= S_W'(s_sum);
            end
            default: ;
         endcase
      end
   end

   assign seg_ready = (state == ST_IDLE) && !reset;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
endmodule

// File: tb/tb_bezier_stepper.sv
// tb/tb_bezier_stepper.sv - directed self-checking bench for bezier_stepper
module tb_bezier_stepper;
   import bezier_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              seg_valid = 1'b0;
   logic              seg_ready;
   logic signed [31:0] p1 [3];
   logic signed [31:0] p2 [3];
   logic signed [31:0] p3 [3];
   logic signed [16:0] ds = '0;
   logic [15:0]        period = '0;
   logic [2:0]         step, dir;
   logic signed [17:0] pos [3];
   logic               busy, done, underrun;

   int total = 0;
   int bad = 0;
   int pulses [3] = '{0, 0, 0};
   int dones = 0;
   int samples = 0;
   int viol = 0;
   logic [2:0] prev_step = '0;
   logic [2:0] prev_dir = '0;

   bezier_stepper #(.PULSE_W(4), .PER_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .seg_valid  (seg_valid),
      .seg_ready  (seg_ready),
      .seg_p1     (p1),
      .seg_p2     (p2),
      .seg_p3     (p3),
      .seg_ds     (ds),
      .seg_period (period),
      .step       (step),
      .dir        (dir),
      .pos        (pos),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            if (step[i] && !prev_step[i]) pulses[i]++;
            if (step[i] && (dir[i] !== prev_dir[i])) viol++;
         end
         if (done) dones++;
         if (dut.state == ST_SAMPLE || dut.state == ST_FINAL) samples++;
      end
      prev_step = step;
      prev_dir  = dir;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic send(input logic signed [16:0] ds_v, input logic [15:0] per_v);
      ds        = ds_v;
      period    = per_v;
      seg_valid = 1'b1;
      check("ready_before_accept", seg_ready, 1);
      tick();
      seg_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("ready_after_accept", seg_ready, 0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      d0 = dones;
      for (int k = 0; k < budget && dones == d0; k++) tick();
      for (int k = 0; k < 3; k++) tick();
      check({tag, "_done_once"}, dones - d0, 1);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int p0 [3];
      int s0, v0, d0;
      p1 = '{0, 0, 0};
      p2 = '{0, 0, 0};
      p3 = '{0, 0, 0};

      // reset held 3 cycles
      tick();
      check("ready_in_reset", seg_ready, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_ready", seg_ready, 1);
      check("rst_step", step, 0);
      check("rst_dir", dir, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_underrun", underrun, 0);
      for (int i = 0; i < 3; i++) check("rst_pos", pos[i], 0);

      // axis 0, +100 steps, 16 samples + FINAL
      p0 = pulses; s0 = samples; v0 = viol;
      p1 = '{100*65536, 0, 0};
      p2 = '{100*65536, 0, 0};
      p3 = '{100*65536, 0, 0};
      send(17'h1000, 16'd64);
      wait_done("pos100", 8000);
      check("pos100_pulses0", pulses[0] - p0[0], 100);
      check("pos100_pulses1", pulses[1] - p0[1], 0);
      check("pos100_pulses2", pulses[2] - p0[2], 0);
      check("pos100_dir0", dir[0], 1);
      check("pos100_pos0", pos[0], 100);
      check("pos100_pos1", pos[1], 0);
      check("pos100_pos2", pos[2], 0);
      check("pos100_samples", samples - s0, 17);
      check("pos100_underrun", underrun, 1);
      check("pos100_dir_viol", viol - v0, 0);

      // axis 1, -50 steps
      p0 = pulses; v0 = viol;
      p1 = '{0, -50*65536, 0};
      p2 = '{0, -50*65536, 0};
      p3 = '{0, -50*65536, 0};
      send(17'h1000, 16'd64);
      wait_done("neg50", 8000);
      check("neg50_pulses1", pulses[1] - p0[1], 50);
      check("neg50_pulses0", pulses[0] - p0[0], 0);
      check("neg50_dir1", dir[1], 0);
      check("neg50_pos1", pos[1], -50);
      check("neg50_pos0", pos[0], 0);
      check("neg50_dir_viol", viol - v0, 0);

      // exact endpoint with ds = 0x8000
      s0 = samples; v0 = viol;
      p1 = '{3*65536 + 1234, 5*65536, -2*65536};
      p2 = '{10*65536, -8*65536 + 777, 4*65536};
      p3 = '{7*65536, -3*65536, 0};
      send(17'h8000, 16'd16);
      wait_done("endpt", 4000);
      check("endpt_pos0", pos[0], 7);
      check("endpt_pos1", pos[1], -3);
      check("endpt_pos2", pos[2], 0);
      check("endpt_samples", samples - s0, 3);
      check("endpt_dir_viol", viol - v0, 0);

      // underrun: reset first so the sticky flag starts clear
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("ur_clear", underrun, 0);
      p0 = pulses;
      p1 = '{0, 0, 20*65536};
      p2 = '{0, 0, 20*65536};
      p3 = '{0, 0, 20*65536};
      send(17'h8000, 16'd1);
      wait_done("ur", 4000);
      check("ur_flag", underrun, 1);
      check("ur_pulses2", pulses[2] - p0[2], 20);
      check("ur_pos2", pos[2], 20);
      check("ur_pulses0", pulses[0] - p0[0], 0);

      // reset during the 5th pulse
      p0 = pulses;
      p1 = '{30*65536, 0, 0};
      p2 = '{30*65536, 0, 0};
      p3 = '{30*65536, 0, 0};
      send(17'h1000, 16'd4);
      for (int k = 0; k < 2000 && (pulses[0] - p0[0]) < 5; k++) tick();
      check("mid_fifth_pulse", pulses[0] - p0[0], 5);
      check("mid_step_high", step[0], 1);
      d0 = dones;
      reset = 1'b1;
      tick();
      check("mid_step", step, 0);
      check("mid_pos0", pos[0], 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_ready_in_reset", seg_ready, 0);
      reset = 1'b0;
      tick();
      check("mid_ready_after", seg_ready, 1);
      for (int k = 0; k < 20; k++) tick();
      check("mid_no_done", dones - d0, 0);
      check("mid_still_idle", busy, 0);

      p0 = pulses; s0 = samples;
      p1 = '{10*65536, 0, 0};
      p2 = '{10*65536, 0, 0};
      p3 = '{10*65536, 0, 0};
      send(17'h4000, 16'd8);
      wait_done("after", 4000);
      check("after_pos0", pos[0], 10);
      check("after_pulses0", pulses[0] - p0[0], 10);
      check("after_samples", samples - s0, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bezier_stepper.md
# bezier_stepper

Sequential driver for the combinational cubic-Bézier evaluator: accepts one curve segment per handshake, sweeps the curve parameter `s` from 0 towards 1, samples the evaluator once per sample period and converts each change in per-axis position into step/direction pulses. It sits between the segment queue and the motor-driver pins and is the consumer of the evaluator's `steps` output.

## Interface
- `AXES`, 3, number of axes; fixed at 3 to match the evaluator.
- `PULSE_W`, 4, high cycles and minimum low cycles of each step pulse.
- `PER_W`, 16, width of the sample-period counter.
- `clk` in 1, single clock; all logic rising-edge.
- `reset` in 1, synchronous, active-high.
- `seg_valid` in 1, segment offered.
- `seg_ready` out 1, high only in IDLE.
- `seg_p1`, `seg_p2`, `seg_p3` in [3] x 32 signed, control points relative to the segment start (P0 = 0), 16.16 fixed-point steps.
- `seg_ds` in 17 signed, Q0.16 increment of `s` per sample; 1..65535 legal.
- `seg_period` in PER_W, minimum cycles between samples; 0 is treated as 1.
- `step` out [3] x 1, step pulses.
- `dir` out [3] x 1, 1 = positive.
- `pos` out [3] x 18 signed, steps emitted in this segment.
- `busy` out 1, not IDLE.
- `done` out 1, one-cycle pulse at segment end.
- `underrun` out 1, sticky; set when a sample's steps exceed the period budget; cleared only by reset.

## Operation
- States: IDLE, SAMPLE, EMIT, FINAL, DONE.
- IDLE: `seg_ready`=1; on `seg_valid & seg_ready`, latch all `seg_*` inputs, clear `s`, `pos` and the per-axis step counters, go to SAMPLE.
- SAMPLE: drive the evaluator with the latched points and `s`; register its 18-bit `steps` into `target[i]`; load the period counter; go to EMIT.
- Evaluator contract: position = floor(B(s) / 2^16), taken as bits [81:64] of the 82-bit sum; `s` is Q0.16 in 17-bit signed, so s = 1.0 is not representable.
- EMIT: per axis, `delta = target - pos`. While delta != 0, set `dir` = (delta > 0), then emit one pulse: PULSE_W cycles high, then PULSE_W cycles low. Move `pos` by ±1 on the falling edge of `step`. Axes run in parallel.
- EMIT exits when all deltas are 0 and the period counter has expired. If the counter expires with any delta != 0, set `underrun` and keep emitting; the period stretches and no steps are dropped.
- On exit, form the 18-bit sum `s + ds`. If the sum is < 65536, store it in `s` and go to SAMPLE. Otherwise go to FINAL.
- FINAL: `target[i]` = `seg_p3[i] >>> 16` (exact endpoint, bypassing the evaluator), then run EMIT rules once more and go to DONE.
- DONE: `done`=1 for one cycle, go to IDLE. `pos` holds its final value until the next accept.
- Width rules: `delta` is computed in 19 bits. Endpoint coordinates must fit 18-bit signed; larger values are outside the contract.

## Timing
- Reset values: `seg_ready`=0 during reset and 1 the first cycle after. `step`, `dir`, `busy`, `done`, `underrun` = 0. `pos` = 0. State = IDLE.
- Reset asserted in any state: the next cycle shows reset values, `done` is not issued, and the latched segment is discarded.
- Accept at cycle T: `busy`=1 from T+1; SAMPLE at T+1; first `dir` update no earlier than T+2.
- `dir` changes only while `step`=0 and at least 1 cycle before the rising edge of `step`.
- Minimum step period per axis is 2·PULSE_W cycles.
- Sample count = ceil(65536 / ds) evaluator samples + 1 FINAL.

## Structure
- Shared package `bezier_pkg`: `AXES`, `S_ONE` = 65536, `POS_W` = 18, `CP_W` = 32, the state enum, and the `point_t` array typedef.
- One sub-module: `step_pulse_gen`, a per-axis instance that takes `delta` and `dir`, outputs the pulse, a ±1 `pos` update, and an idle flag. The evaluator is instantiated once.

## Test plan
- Reset: hold `reset` 3 cycles, then release → all outputs 0 and `seg_ready`=1 on the first cycle after release.
- Axis 0, p1=p2=p3=100·2^16, ds=0x1000, period=64 → exactly 100 pulses, `dir[0]`=1, `pos[0]`=100, axes 1/2 silent, one `done`, 17 samples.
- Axis 1, p1=p2=p3=−50·2^16 → 50 pulses, `dir[1]`=0, `pos[1]`=−50; `dir` stable ≥1 cycle before every rising edge of `step`.
- Endpoint: ds=0x8000, p3=(7,−3,0)·2^16, random p1/p2 → samples at s=0 and 0x8000 plus FINAL; final `pos`=(7,−3,0).
- Underrun: period=1, target 20 steps on axis 2, PULSE_W=4 → `underrun` set, 20 pulses, none dropped.
- Reset at the 5th pulse in EMIT → next cycle `step`=0, `pos`=0, IDLE, no `done`; a new segment accepted afterwards completes normally.
